regfile_sb: RTL and testbench

Parametrised multi-port register file with an integrated scoreboard for the pipelined MIPS CPU. Replaces the fixed 32x32, two-read, one-write register file in the decode stage. Adds a configurable number of combinational read ports, optional write-to-read bypass, synchronous active-low reset of all registers, and per-register busy bits. The hazard unit uses the busy bits to stall on RAW/WAW hazards and to flush them on pipeline redirect.

---
 rtl/regfile_sb.sv | 88 ++++++++
 tb/tb_regfile_sb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard for the pipelined MIPS decode stage.
// Reads are combinational with optional same-cycle write bypass; busy bits track pending producers.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_no,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        reg_no_in,
  input  logic [DATA_W-1:0]        reg_data_in,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_no,
  output logic                     issue_ok,
  input  logic                     sb_flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr_eff;
  logic              issue_zero;

  assign wr_eff     = reg_write && !((ZERO_REG != 0) && (reg_no_in == '0));
  assign issue_zero = (ZERO_REG != 0) && (issue_no == '0);

  // A busy target may still issue when its producer retires in this same cycle.
  assign issue_ok = rst_n && issue_valid && !sb_flush &&
                    (issue_zero || !busy[issue_no] || (wr_eff && (reg_no_in == issue_no)));

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] rno;
    logic              byp;

    assign rno = rd_no[g*ADDR_W +: ADDR_W];
    assign byp = (BYPASS != 0) && wr_eff && (reg_no_in == rno);

    assign rd_data[g*DATA_W +: DATA_W] =
      (!rst_n || ((ZERO_REG != 0) && (rno == '0))) ? '0 :
      byp ? reg_data_in : mem[rno];

    assign rd_busy[g] = rst_n && !byp && busy[rno];
  end

  // Set after clear: a new producer issuing in the retire cycle keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (sb_flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_eff)
        busy_nxt[reg_no_in] = 1'b0;
      if (issue_ok && !issue_zero)
        busy_nxt[issue_no] = 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int j = 0; j < DEPTH; j++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[j]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++)
        mem[k] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_eff)
        mem[reg_no_in] <= reg_data_in;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table plus randomized traffic against a behavioural model.
// Two instances (bypass on and off) share all inputs.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_no;
  logic [63:0] rd_data;
  logic [63:0] rd_data_nb;
  logic [1:0]  rd_busy;
  logic [1:0]  rd_busy_nb;
  logic        reg_write;
  logic [4:0]  reg_no_in;
  logic [31:0] reg_data_in;
  logic        issue_valid;
  logic [4:0]  issue_no;
  logic        issue_ok;
  logic        issue_ok_nb;
  logic        sb_flush;
  logic [5:0]  busy_cnt;
  logic [5:0]  busy_cnt_nb;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem_m [32];
  bit          busy_m [32];

  regfile_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_no(rd_no), .rd_data(rd_data), .rd_busy(rd_busy),
    .reg_write(reg_write), .reg_no_in(reg_no_in), .reg_data_in(reg_data_in),
    .issue_valid(issue_valid), .issue_no(issue_no), .issue_ok(issue_ok),
    .sb_flush(sb_flush), .busy_cnt(busy_cnt)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_no(rd_no), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .reg_write(reg_write), .reg_no_in(reg_no_in), .reg_data_in(reg_data_in),
    .issue_valid(issue_valid), .issue_no(issue_no), .issue_ok(issue_ok_nb),
    .sb_flush(sb_flush), .busy_cnt(busy_cnt_nb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        wr;
    logic [4:0]  wno;
    logic [31:0] wdata;
    logic        iv;
    logic [4:0]  ino;
    logic        fl;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic        e_b0;
    logic        e_b1;
    logic        e_ok;
    logic [5:0]  e_cnt;
    logic [31:0] e_nb0;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic rst, input logic wr, input logic [4:0] wno,
                              input logic [31:0] wdata, input logic iv, input logic [4:0] ino,
                              input logic fl, input logic [4:0] r0, input logic [4:0] r1,
                              input logic [31:0] e_d0, input logic [31:0] e_d1,
                              input logic e_b0, input logic e_b1, input logic e_ok,
                              input logic [5:0] e_cnt, input logic [31:0] e_nb0);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wno = wno; v.wdata = wdata; v.iv = iv; v.ino = ino; v.fl = fl;
    v.r0 = r0; v.r1 = r1; v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_b0 = e_b0; v.e_b1 = e_b1;
    v.e_ok = e_ok; v.e_cnt = e_cnt; v.e_nb0 = e_nb0;
    return v;
  endfunction

  // Reference model: architectural register contents and set of pending producers.
  function automatic logic m_wr_eff();
    return reg_write && (reg_no_in != 5'd0);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] n, input bit byp);
    if (!rst_n || n == 5'd0) return 32'd0;
    if (byp && m_wr_eff() && reg_no_in == n) return reg_data_in;
    return mem_m[n];
  endfunction

  function automatic logic m_busy(input logic [4:0] n, input bit byp);
    if (!rst_n) return 1'b0;
    if (byp && m_wr_eff() && reg_no_in == n) return 1'b0;
    return busy_m[n];
  endfunction

  function automatic logic m_ok();
    return rst_n && issue_valid && !sb_flush &&
           (issue_no == 5'd0 || !busy_m[issue_no] || (m_wr_eff() && reg_no_in == issue_no));
  endfunction

  function automatic logic [5:0] m_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) if (busy_m[i]) c++;
    return 6'(c);
  endfunction

  task automatic model_step();
    logic ok;
    ok = m_ok();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_m[i] = 32'd0;
        busy_m[i] = 1'b0;
      end
    end else begin
      if (m_wr_eff()) mem_m[reg_no_in] = reg_data_in;
      if (sb_flush) begin
        for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
      end else begin
        if (m_wr_eff()) busy_m[reg_no_in] = 1'b0;
        if (ok && issue_no != 5'd0) busy_m[issue_no] = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic wr, input logic [4:0] wno,
                               input logic [31:0] wdata, input logic iv, input logic [4:0] ino,
                               input logic fl, input logic [4:0] r0, input logic [4:0] r1);
    rst_n = rst; reg_write = wr; reg_no_in = wno; reg_data_in = wdata;
    issue_valid = iv; issue_no = ino; sb_flush = fl;
    rd_no = {r1, r0};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    #1;
    next_cycle();

    vecs[0]  = mk(0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 0, 5'd5, 5'd5, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 5'd6, 32'h1, 1, 5'd7, 1, 5'd5, 5'd5, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd5, 5'd6, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 5'd7, 32'h12345678, 0, 5'd0, 0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 0, 0, 0, 0, 32'h12345678);
    vecs[6]  = mk(1, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0);
    vecs[7]  = mk(1, 0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd0, 5'd3, 0, 0, 0, 0, 1, 0, 0);
    vecs[8]  = mk(1, 0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd3, 5'd3, 0, 0, 1, 1, 0, 1, 0);
    vecs[9]  = mk(1, 1, 5'd3, 32'h55, 0, 5'd0, 0, 5'd3, 5'd3, 32'h55, 32'h55, 0, 0, 0, 1, 0);
    vecs[10] = mk(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd3, 5'd3, 32'h55, 32'h55, 0, 0, 0, 0, 32'h55);
    vecs[11] = mk(1, 0, 5'd0, 32'h0, 1, 5'd9, 0, 5'd9, 5'd9, 0, 0, 0, 0, 1, 0, 0);
    vecs[12] = mk(1, 1, 5'd9, 32'h99, 1, 5'd9, 0, 5'd9, 5'd9, 32'h99, 32'h99, 0, 0, 1, 1, 0);
    vecs[13] = mk(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd9, 5'd9, 32'h99, 32'h99, 1, 1, 0, 1, 32'h99);
    vecs[14] = mk(1, 1, 5'd9, 32'h77, 0, 5'd0, 0, 5'd9, 5'd9, 32'h77, 32'h77, 0, 0, 0, 1, 32'h99);
    vecs[15] = mk(1, 0, 5'd0, 32'h0, 1, 5'd1, 0, 5'd1, 5'd9, 0, 32'h77, 0, 0, 1, 0, 0);
    vecs[16] = mk(1, 0, 5'd0, 32'h0, 1, 5'd2, 0, 5'd1, 5'd2, 0, 0, 1, 0, 1, 1, 0);
    vecs[17] = mk(1, 0, 5'd0, 32'h0, 1, 5'd4, 0, 5'd2, 5'd4, 0, 0, 1, 0, 1, 2, 0);
    vecs[18] = mk(1, 1, 5'd2, 32'hA, 1, 5'd6, 1, 5'd2, 5'd6, 32'hA, 0, 0, 0, 0, 3, 0);
    vecs[19] = mk(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd2, 5'd6, 32'hA, 0, 0, 0, 0, 0, 32'hA);
    vecs[20] = mk(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd1, 5'd4, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].wno, vecs[i].wdata, vecs[i].iv,
                    vecs[i].ino, vecs[i].fl, vecs[i].r0, vecs[i].r1);
      #1;
      checkOutput($sformatf("vec%0d rd_data0", i), rd_data[31:0], vecs[i].e_d0);
      checkOutput($sformatf("vec%0d rd_data1", i), rd_data[63:32], vecs[i].e_d1);
      checkOutput($sformatf("vec%0d rd_busy0", i), {31'd0, rd_busy[0]}, {31'd0, vecs[i].e_b0});
      checkOutput($sformatf("vec%0d rd_busy1", i), {31'd0, rd_busy[1]}, {31'd0, vecs[i].e_b1});
      checkOutput($sformatf("vec%0d issue_ok", i), {31'd0, issue_ok}, {31'd0, vecs[i].e_ok});
      checkOutput($sformatf("vec%0d busy_cnt", i), {26'd0, busy_cnt}, {26'd0, vecs[i].e_cnt});
      checkOutput($sformatf("vec%0d nb_rd_data0", i), rd_data_nb[31:0], vecs[i].e_nb0);
      next_cycle();
    end

    for (int n = 0; n < 600; n++) begin
      logic [4:0] r0;
      logic [4:0] r1;
      r0 = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 39) != 0, $urandom_range(0, 1) == 1,
                    5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 4) < 3,
                    5'($urandom_range(0, 7)), $urandom_range(0, 24) == 0, r0, r1);
      #1;
      checkOutput("rnd rd_data0", rd_data[31:0], m_rd(r0, 1'b1));
      checkOutput("rnd rd_data1", rd_data[63:32], m_rd(r1, 1'b1));
      checkOutput("rnd rd_busy0", {31'd0, rd_busy[0]}, {31'd0, m_busy(r0, 1'b1)});
      checkOutput("rnd rd_busy1", {31'd0, rd_busy[1]}, {31'd0, m_busy(r1, 1'b1)});
      checkOutput("rnd issue_ok", {31'd0, issue_ok}, {31'd0, m_ok()});
      checkOutput("rnd busy_cnt", {26'd0, busy_cnt}, {26'd0, m_cnt()});
      checkOutput("rnd nb_rd_data0", rd_data_nb[31:0], m_rd(r0, 1'b0));
      checkOutput("rnd nb_rd_data1", rd_data_nb[63:32], m_rd(r1, 1'b0));
      checkOutput("rnd nb_rd_busy0", {31'd0, rd_busy_nb[0]}, {31'd0, m_busy(r0, 1'b0)});
      checkOutput("rnd nb_rd_busy1", {31'd0, rd_busy_nb[1]}, {31'd0, m_busy(r1, 1'b0)});
      checkOutput("rnd nb_issue_ok", {31'd0, issue_ok_nb}, {31'd0, m_ok()});
      checkOutput("rnd nb_busy_cnt", {26'd0, busy_cnt_nb}, {26'd0, m_cnt()});
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
